// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte request / serial status bundle between control logic and uart_tx
interface uart_tx_if;
  logic       TX_start;
  logic [7:0] TX_byte;
  logic       TX_serial;
  logic       TX_busy;
  logic       TX_done;

  modport master (
    output TX_start,
    output TX_byte,
    input  TX_serial,
    input  TX_busy,
    input  TX_done
  );

  modport slave (
    input  TX_start,
    input  TX_byte,
    output TX_serial,
    output TX_busy,
    output TX_done
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even parity bit
module uart_tx #(
  parameter int CLOCK_TICKS_PER_BIT = 128
) (
  input logic     clock_in,
  input logic     reset_in,
  uart_tx_if.slave tx
);

  localparam int CW = $clog2(CLOCK_TICKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLOCK_TICKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
    TX_STOP_BIT   = 3'd3,
    TX_PARITY_BIT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TX_START_BIT = 3'd1,
    TX_DATA_BITS = 3'd2,
    TX_STOP_BIT  = 3'd3
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          serial_q;
  logic          busy_q;
  logic          done_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  assign tx.TX_serial = serial_q;
  assign tx.TX_busy   = busy_q;
  assign tx.TX_done   = done_q;

  // serial_q is loaded one edge ahead of each bit so the line changes exactly on bit boundaries
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          tick_cnt <= '0;
          bit_idx  <= '0;
          if (tx.TX_start) begin
            shift_reg <= tx.TX_byte;
            serial_q  <= 1'b0;
            busy_q    <= 1'b1;
            state     <= TX_START_BIT;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^tx.TX_byte;
`endif
          end
        end

        TX_START_BIT: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt  <= '0;
            serial_q  <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= TX_DATA_BITS;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        TX_DATA_BITS: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              serial_q <= parity_q;
              state    <= TX_PARITY_BIT;
`else
              serial_q <= 1'b1;
              state    <= TX_STOP_BIT;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              serial_q  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        TX_PARITY_BIT: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            serial_q <= 1'b1;
            state    <= TX_STOP_BIT;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif

        TX_STOP_BIT: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_idx  <= '0;
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
